// File: rtl/gcd_reduce_client.sv
// gcd_reduce_client: reduces a stream of 16-bit operands to their GCD
// by driving an external GCD unit, and emits one {count, gcd} result per sequence.
//
// Parameters:
//   p_cnt_nbits  width of the per-sequence element counter (saturating)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   istream_val/rdy/msg      operand input, msg = {last, value[15:0]}
//   gcdreq_val/rdy/msg       request to GCD unit, msg = {acc, opnd}
//   gcdresp_val/rdy/msg      16-bit result from GCD unit
//   ostream_val/rdy/msg      reduction result, msg = {cnt, acc}
//
// Build option:
//   GCD_REDUCE_SHORTCUT_EN   when defined, skips the GCD request when the
//                            running GCD is already 1 or the new operand is 0.

module gcd_reduce_client #(
   parameter int p_cnt_nbits = 8
) (
   input  logic                      clk,
   input  logic                      rst,

   input  logic                      istream_val,
   output logic                      istream_rdy,
   input  logic [16:0]               istream_msg,

   output logic                      gcdreq_val,
   input  logic                      gcdreq_rdy,
   output logic [31:0]               gcdreq_msg,

   input  logic                      gcdresp_val,
   output logic                      gcdresp_rdy,
   input  logic [15:0]               gcdresp_msg,

   output logic                      ostream_val,
   input  logic                      ostream_rdy,
   output logic [16+p_cnt_nbits-1:0] ostream_msg
);

   typedef enum logic [2:0] {
      IDLE,
      ACCUM,
      REQ,
      RESP,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [15:0]            acc;
   logic [15:0]            acc_next;
   logic [15:0]            opnd;
   logic [15:0]            opnd_next;
   logic                   last_reg;
   logic                   last_next;
   logic [p_cnt_nbits-1:0] cnt;
   logic [p_cnt_nbits-1:0] cnt_next;
   logic [p_cnt_nbits-1:0] cnt_inc;

   logic                   in_last;
   logic [15:0]            in_value;
   logic                   in_fire;
   logic                   req_fire;
   logic                   resp_fire;
   logic                   out_fire;
   logic                   shortcut;

   assign in_last  = istream_msg[16];
   assign in_value = istream_msg[15:0];

   // Counter holds at all-ones instead of wrapping.
   assign cnt_inc = (cnt == {p_cnt_nbits{1'b1}})
                  ? cnt
                  : cnt + p_cnt_nbits'(1);

`ifdef GCD_REDUCE_SHORTCUT_EN
   // gcd(1,x)=1 and gcd(x,0)=x: the accumulator is already the answer.
   assign shortcut = (acc == 16'd1) || (in_value == 16'd0);
`else
   assign shortcut = 1'b0;
`endif

   // Moore handshake outputs, held low while reset is asserted.
   always_comb begin
      istream_rdy = 1'b0;
      gcdreq_val  = 1'b0;
      gcdresp_rdy = 1'b0;
      ostream_val = 1'b0;
      if (!rst) begin
         unique case (state)
            IDLE:    istream_rdy = 1'b1;
            ACCUM:   istream_rdy = 1'b1;
            REQ:     gcdreq_val  = 1'b1;
            RESP:    gcdresp_rdy = 1'b1;
            DONE:    ostream_val = 1'b1;
            default: ;
         endcase
      end
   end

   assign gcdreq_msg  = {acc, opnd};
   assign ostream_msg = {cnt, acc};

   assign in_fire   = istream_val & istream_rdy;
   assign req_fire  = gcdreq_val  & gcdreq_rdy;
   assign resp_fire = gcdresp_val & gcdresp_rdy;
   assign out_fire  = ostream_val & ostream_rdy;

   always_comb begin
      state_next = state;
      acc_next   = acc;
      opnd_next  = opnd;
      last_next  = last_reg;
      cnt_next   = cnt;
      unique case (state)
         IDLE: begin
            if (in_fire) begin
               acc_next   = in_value;
               cnt_next   = p_cnt_nbits'(1);
               state_next = in_last ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (in_fire) begin
               cnt_next = cnt_inc;
               if (shortcut) begin
                  state_next = in_last ? DONE : ACCUM;
               end else begin
                  opnd_next  = in_value;
                  last_next  = in_last;
                  state_next = REQ;
               end
            end
         end
         REQ: begin
            if (req_fire) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if (resp_fire) begin
               acc_next   = gcdresp_msg;
               state_next = last_reg ? DONE : ACCUM;
            end
         end
         DONE: begin
            if (out_fire) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         acc      <= 16'd0;
         opnd     <= 16'd0;
         last_reg <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= state_next;
         acc      <= acc_next;
         opnd     <= opnd_next;
         last_reg <= last_next;
         cnt      <= cnt_next;
      end
   end

endmodule

// File: tb/tb_gcd_reduce_client.sv
// tb_gcd_reduce_client: directed bench for gcd_reduce_client with an
// ideal GCD unit model, result scoreboard and handshake stability monitors.

module tb_gcd_reduce_client;

   localparam int N = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          istream_val;
   logic          istream_rdy;
   logic [16:0]   istream_msg;
   logic          gcdreq_val;
   logic          gcdreq_rdy;
   logic [31:0]   gcdreq_msg;
   logic          gcdresp_val;
   logic          gcdresp_rdy;
   logic [15:0]   gcdresp_msg;
   logic          ostream_val;
   logic          ostream_rdy;
   logic [N+15:0] ostream_msg;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_q[$];
   logic [31:0] req_q[$];

   int          req_stall  = 0;
   int          resp_stall = 0;
   logic        r_busy     = 1'b0;
   logic [15:0] r_res      = 16'd0;
   int          r_cnt      = 0;
   int          r_wait     = 0;

   logic        prev_req_stall = 1'b0;
   logic [31:0] prev_req_msg   = '0;
   logic        prev_out_stall = 1'b0;
   logic [31:0] prev_out_msg   = '0;

   gcd_reduce_client #(.p_cnt_nbits(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .istream_val (istream_val),
      .istream_rdy (istream_rdy),
      .istream_msg (istream_msg),
      .gcdreq_val  (gcdreq_val),
      .gcdreq_rdy  (gcdreq_rdy),
      .gcdreq_msg  (gcdreq_msg),
      .gcdresp_val (gcdresp_val),
      .gcdresp_rdy (gcdresp_rdy),
      .gcdresp_msg (gcdresp_msg),
      .ostream_val (ostream_val),
      .ostream_rdy (ostream_rdy),
      .ostream_msg (ostream_msg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] gcd(input logic [15:0] a,
                                       input logic [15:0] b);
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] t;
      x = a;
      y = b;
      while (y != 16'd0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // GCD unit model: handshake capture on the active edge.
   always @(posedge clk) begin
      if (rst) begin
         r_busy = 1'b0;
         r_cnt  = 0;
      end else begin
         if (gcdreq_val && gcdreq_rdy) begin
            req_q.push_back(gcdreq_msg);
            r_res  = gcd(gcdreq_msg[31:16], gcdreq_msg[15:0]);
            r_busy = 1'b1;
            r_cnt  = resp_stall;
         end
         if (gcdresp_val && gcdresp_rdy) begin
            r_busy = 1'b0;
         end
      end
   end

   // GCD unit model: drive its outputs away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         gcdreq_rdy  = 1'b0;
         gcdresp_val = 1'b0;
         gcdresp_msg = 16'd0;
         r_wait      = 0;
      end else begin
         if (gcdreq_val && !r_busy) begin
            if (r_wait >= req_stall) begin
               gcdreq_rdy = 1'b1;
            end else begin
               gcdreq_rdy = 1'b0;
               r_wait++;
            end
         end else begin
            gcdreq_rdy = 1'b0;
            r_wait     = 0;
         end
         if (r_busy && r_cnt > 0) begin
            gcdresp_val = 1'b0;
            r_cnt--;
         end else if (r_busy) begin
            gcdresp_val = 1'b1;
            gcdresp_msg = r_res;
         end else begin
            gcdresp_val = 1'b0;
         end
      end
   end

   // Result scoreboard and stability monitors.
   always @(posedge clk) begin
      if (rst) begin
         prev_req_stall = 1'b0;
         prev_out_stall = 1'b0;
      end else begin
         if (ostream_val && ostream_rdy) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", {8'h0, ostream_msg}, 32'h0);
            end else begin
               chk("result", {8'h0, ostream_msg}, exp_q.pop_front());
            end
         end
         if (gcdreq_val && prev_req_stall)
            chk("req_msg_stable", gcdreq_msg, prev_req_msg);
         if (ostream_val && prev_out_stall)
            chk("out_msg_stable", {8'h0, ostream_msg}, prev_out_msg);
         if (gcdreq_val || gcdresp_rdy || ostream_val)
            chk("istream_rdy_busy", {31'h0, istream_rdy}, 32'h0);
         prev_req_stall = gcdreq_val && !gcdreq_rdy;
         prev_req_msg   = gcdreq_msg;
         prev_out_stall = ostream_val && !ostream_rdy;
         prev_out_msg   = {8'h0, ostream_msg};
      end
   end

   task automatic send(input logic [15:0] v, input logic l);
      int n = 0;
      @(negedge clk);
      istream_val = 1'b1;
      istream_msg = {l, v};
      while (!istream_rdy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("send_timeout", n, 0);
      @(posedge clk);
      #1 istream_val = 1'b0;
   endtask

   task automatic wait_empty();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst         = 1'b1;
      istream_val = 1'b0;
      istream_msg = 17'd0;
      ostream_rdy = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_istream_rdy", {31'h0, istream_rdy}, 0);
      chk("rst_gcdreq_val", {31'h0, gcdreq_val}, 0);
      chk("rst_gcdresp_rdy", {31'h0, gcdresp_rdy}, 0);
      chk("rst_ostream_val", {31'h0, ostream_val}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ostream_msg", {8'h0, ostream_msg}, 0);
      chk("idle_istream_rdy", {31'h0, istream_rdy}, 1);

      // Basic sequence 12, 18, 30
      req_q.delete();
      exp_q.push_back({8'h0, 8'd3, 16'h0006});
      send(16'd12, 1'b0);
      send(16'd18, 1'b0);
      send(16'd30, 1'b1);
      wait_empty();
      chk("basic_nreq", req_q.size(), 2);
      chk("basic_req0", req_q[0], 32'h000C_0012);
      chk("basic_req1", req_q[1], 32'h0006_001E);

      // Single element
      req_q.delete();
      exp_q.push_back({8'h0, 8'd1, 16'h0005});
      send(16'd5, 1'b1);
      @(negedge clk);
      chk("single_val", {31'h0, ostream_val}, 1);
      wait_empty();
      chk("single_nreq", req_q.size(), 0);

      // Backpressure on all three partner streams
      req_q.delete();
      req_stall   = 5;
      resp_stall  = 3;
      ostream_rdy = 1'b0;
      exp_q.push_back({8'h0, 8'd2, 16'd12});
      send(16'd48, 1'b0);
      send(16'd36, 1'b1);
      n = 0;
      while (!ostream_val && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("bp_reach_done", {31'h0, ostream_val}, 1);
      for (int i = 0; i < 4; i++) begin
         chk("bp_out_val", {31'h0, ostream_val}, 1);
         chk("bp_out_msg", {8'h0, ostream_msg}, {8'h0, 8'd2, 16'd12});
         @(negedge clk);
      end
      ostream_rdy = 1'b1;
      wait_empty();
      chk("bp_nreq", req_q.size(), 1);
      chk("bp_req0", req_q[0], 32'h0030_0024);
      req_stall  = 0;
      resp_stall = 0;

      // Shortcut candidates 7, 3, 9, 0
      req_q.delete();
      exp_q.push_back({8'h0, 8'd4, 16'h0001});
      send(16'd7, 1'b0);
      send(16'd3, 1'b0);
      send(16'd9, 1'b0);
      send(16'd0, 1'b1);
      wait_empty();
      chk("sc_req0", req_q[0], 32'h0007_0003);
`ifdef GCD_REDUCE_SHORTCUT_EN
      chk("sc_nreq", req_q.size(), 1);
`else
      chk("sc_nreq", req_q.size(), 3);
      chk("sc_req2", req_q[2], 32'h0001_0000);
`endif

      // Reset while waiting for a GCD response
      resp_stall = 20;
      send(16'd8, 1'b0);
      send(16'd12, 1'b1);
      n = 0;
      while (!gcdresp_rdy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("mid_in_resp", {31'h0, gcdresp_rdy}, 1);
      rst = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      resp_stall = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("mid_no_result", {31'h0, ostream_val}, 0);
      end
      chk("mid_msg_cleared", {8'h0, ostream_msg}, 0);
      exp_q.push_back({8'h0, 8'd2, 16'h0002});
      send(16'd4, 1'b0);
      send(16'd6, 1'b1);
      wait_empty();

      // Counter saturation
      exp_q.push_back({8'h0, 8'hFF, 16'h0008});
      for (int i = 0; i < 299; i++) send(16'd8, 1'b0);
      send(16'd8, 1'b1);
      wait_empty();

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
